// File: rtl/mdio_apb_pkg.sv
// Shared constants, register offsets and engine state encoding for the
// APB-controlled Clause-22 MDIO master.
package mdio_apb_pkg;

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h04;
  localparam logic [7:0] ADDR_NAME2   = 8'h08;
  localparam logic [7:0] ADDR_NAME3   = 8'h0C;
  localparam logic [7:0] ADDR_COMP0   = 8'h10;
  localparam logic [7:0] ADDR_COMP1   = 8'h14;
  localparam logic [7:0] ADDR_COMP2   = 8'h18;
  localparam logic [7:0] ADDR_COMP3   = 8'h1C;
  localparam logic [7:0] ADDR_VERSION = 8'h20;
  localparam logic [7:0] ADDR_CONTROL = 8'h30;
  localparam logic [7:0] ADDR_STATUS  = 8'h34;
  localparam logic [7:0] ADDR_WR_CMD  = 8'h38;
  localparam logic [7:0] ADDR_RD_CMD  = 8'h3C;

  // ASCII identification words, first character in the top byte
  localparam logic [31:0] NAME0_VAL   = 32'h4D44494F;  // "MDIO"
  localparam logic [31:0] NAME1_VAL   = 32'h414D4241;  // "AMBA"
  localparam logic [31:0] NAME_PAD    = 32'h20202020;  // "    "
  localparam logic [31:0] COMP0_VAL   = 32'h46555455;  // "FUTU"
  localparam logic [31:0] COMP1_VAL   = 32'h52452044;  // "RE D"
  localparam logic [31:0] COMP2_VAL   = 32'h45534947;  // "ESIG"
  localparam logic [31:0] COMP3_VAL   = 32'h4E202020;  // "N   "
  localparam logic [31:0] VERSION_VAL = 32'h20181011;

  localparam logic [1:0] ST_BITS  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam logic [5:0] HDR_WR = 6'b110101;
  localparam logic [5:0] HDR_RD = 6'b110110;

  // Index of the final bit of each frame section within the 64-bit frame
  localparam logic [5:0] LAST_PRE  = 6'd31;
  localparam logic [5:0] LAST_HDR  = 6'd45;
  localparam logic [5:0] LAST_TA   = 6'd47;
  localparam logic [5:0] LAST_DATA = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_FIN
  } eng_state_e;

endpackage

// File: rtl/mdio_apb_master_if.sv
// APB3 slave-side bus bundle used by the MDIO master.
interface mdio_apb_master_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (output PSEL, output PENABLE, output PWRITE,
                  output PADDR, output PWDATA, input PRDATA);
  modport slave  (input PSEL, input PENABLE, input PWRITE,
                  input PADDR, input PWDATA, output PRDATA);
endinterface

// File: rtl/mdio_apb_engine.sv
// MDC divider, frame sequencer and MDIO pad control. One command runs a
// 64-bit Clause-22 frame; fin is high for the single cycle after the last bit.
module mdio_apb_engine
  import mdio_apb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] div,
  input  logic        start,
  input  logic        is_read,
  input  logic [4:0]  phyad,
  input  logic [4:0]  regad,
  input  logic [15:0] wdata,
  input  logic        mdio_i,
  output logic        busy,
  output logic        fin,
  output logic        rd_frame,
  output logic [15:0] rdata,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t
);

  eng_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic        mdc_q, mdc_d;
  logic [63:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        rd_q, rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      mdc_q   <= 1'b0;
      tx_q    <= '1;
      rx_q    <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      mdc_q   <= mdc_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    mdc_d   = mdc_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRE;
          cnt_d   = div;
          bit_d   = '0;
          mdc_d   = 1'b0;
          rd_d    = is_read;
          // Released TA/data bits carry 1s so the idle level is kept on MDIO_O
          tx_d    = {32'hFFFF_FFFF, ST_BITS, is_read ? OP_READ : OP_WRITE,
                     phyad, regad, is_read ? 2'b11 : TA_WRITE,
                     is_read ? 16'hFFFF : wdata};
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!en) begin
          state_d = S_IDLE;
          mdc_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d = div;
          mdc_d = !mdc_q;
          if (!mdc_q) begin
            if (state_q == S_DATA) rx_d = {rx_q[14:0], mdio_i};
          end else begin
            // Falling edge ends the current bit and presents the next one
            bit_d = bit_q + 6'd1;
            tx_d  = {tx_q[62:0], 1'b1};
            case (bit_q)
              LAST_PRE:  state_d = S_HDR;
              LAST_HDR:  state_d = S_TA;
              LAST_TA:   state_d = S_DATA;
              LAST_DATA: state_d = S_FIN;
              default:   ;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    fin      = (state_q == S_FIN);
    rd_frame = rd_q;
    rdata    = rx_q;
    mdc      = mdc_q;
    mdio_o   = 1'b1;
    mdio_t   = 1'b1;
    case (state_q)
      S_PRE, S_HDR: begin
        mdio_t = 1'b0;
        mdio_o = tx_q[63];
      end
      S_TA, S_DATA: begin
        mdio_t = rd_q;
        mdio_o = tx_q[63];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdio_apb_master.sv
// APB3 CSR block for the Clause-22 MDIO master: identification registers,
// control/status and write/read command registers around the frame engine.
module mdio_apb_master
  import mdio_apb_pkg::*;
#(
  parameter int P_CLK_FREQ = 50_000_000,
  parameter int P_MDC_FREQ = 2_500_000
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  mdio_apb_master_if.slave        apb,
  output logic                    IRQ,
  output logic                    MDC,
  input  logic                    MDIO_I,
  output logic                    MDIO_O,
  output logic                    MDIO_T
);

  localparam logic [15:0] DIV_RST = 16'(P_CLK_FREQ / (2 * P_MDC_FREQ) - 1);

  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [15:0] div_q, div_d;
  logic        done_q, done_d;
  logic [4:0]  wr_phy_q, wr_phy_d, wr_reg_q, wr_reg_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [4:0]  rd_phy_q, rd_phy_d, rd_reg_q, rd_reg_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [31:0] prdata_q, prdata_d;

  logic [7:0]  addr;
  logic        wr_en, rd_setup, cmd_wr, cmd_rd, start;
  logic [31:0] rd_mux;
  logic        eng_busy, eng_fin, eng_rd;
  logic [15:0] eng_rdata;
  logic        unused_bits;

  assign unused_bits = ^{apb.PADDR[31:8], apb.PWDATA[29:26]};

  assign addr     = apb.PADDR[7:0];
  assign wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_setup = apb.PSEL & !apb.PENABLE & !apb.PWRITE;
  assign cmd_wr   = wr_en && (addr == ADDR_WR_CMD);
  assign cmd_rd   = wr_en && (addr == ADDR_RD_CMD);
  assign start    = (cmd_wr || cmd_rd) && en_q && !eng_busy;

  mdio_apb_engine u_engine (
    .clk      (PCLK),
    .rst      (PRESET),
    .en       (en_q),
    .div      (div_q),
    .start    (start),
    .is_read  (cmd_rd),
    .phyad    (apb.PWDATA[25:21]),
    .regad    (apb.PWDATA[20:16]),
    .wdata    (apb.PWDATA[15:0]),
    .mdio_i   (MDIO_I),
    .busy     (eng_busy),
    .fin      (eng_fin),
    .rd_frame (eng_rd),
    .rdata    (eng_rdata),
    .mdc      (MDC),
    .mdio_o   (MDIO_O),
    .mdio_t   (MDIO_T)
  );

  always_comb begin
    case (addr)
      ADDR_NAME0:   rd_mux = NAME0_VAL;
      ADDR_NAME1:   rd_mux = NAME1_VAL;
      ADDR_NAME2:   rd_mux = NAME_PAD;
      ADDR_NAME3:   rd_mux = NAME_PAD;
      ADDR_COMP0:   rd_mux = COMP0_VAL;
      ADDR_COMP1:   rd_mux = COMP1_VAL;
      ADDR_COMP2:   rd_mux = COMP2_VAL;
      ADDR_COMP3:   rd_mux = COMP3_VAL;
      ADDR_VERSION: rd_mux = VERSION_VAL;
      ADDR_CONTROL: rd_mux = {en_q, ie_q, 14'd0, div_q};
      ADDR_STATUS:  rd_mux = {30'd0, done_q, eng_busy};
      ADDR_WR_CMD:  rd_mux = {HDR_WR, wr_phy_q, wr_reg_q, wr_data_q};
      ADDR_RD_CMD:  rd_mux = {HDR_RD, rd_phy_q, rd_reg_q, rd_data_q};
      default:      rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    en_d      = en_q;
    ie_d      = ie_q;
    div_d     = div_q;
    done_d    = done_q;
    wr_phy_d  = wr_phy_q;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    rd_phy_d  = rd_phy_q;
    rd_reg_d  = rd_reg_q;
    rd_data_d = rd_data_q;
    prdata_d  = prdata_q;
    if (wr_en && addr == ADDR_CONTROL) begin
      en_d  = apb.PWDATA[31];
      ie_d  = apb.PWDATA[30];
      div_d = apb.PWDATA[15:0];
    end
    if (wr_en && addr == ADDR_STATUS && apb.PWDATA[1]) done_d = 1'b0;
    if (start) begin
      done_d = 1'b0;
      if (cmd_wr) begin
        wr_phy_d  = apb.PWDATA[25:21];
        wr_reg_d  = apb.PWDATA[20:16];
        wr_data_d = apb.PWDATA[15:0];
      end else begin
        rd_phy_d = apb.PWDATA[25:21];
        rd_reg_d = apb.PWDATA[20:16];
      end
    end
    // Completion wins over a same-cycle DONE clear
    if (eng_fin) begin
      done_d = 1'b1;
      if (eng_rd) rd_data_d = eng_rdata;
    end
    if (rd_setup) prdata_d = rd_mux;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      div_q     <= DIV_RST;
      done_q    <= 1'b0;
      wr_phy_q  <= '0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      rd_phy_q  <= '0;
      rd_reg_q  <= '0;
      rd_data_q <= '0;
      prdata_q  <= '0;
    end else begin
      en_q      <= en_d;
      ie_q      <= ie_d;
      div_q     <= div_d;
      done_q    <= done_d;
      wr_phy_q  <= wr_phy_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      rd_phy_q  <= rd_phy_d;
      rd_reg_q  <= rd_reg_d;
      rd_data_q <= rd_data_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.PRDATA = prdata_q;
  assign IRQ        = done_q & ie_q;

endmodule

// File: tb/tb_mdio_apb_master.sv
// Bench for mdio_apb_master: APB driver, a behavioural Clause-22 PHY at
// address 1 and a scoreboard of the values software expects in it.
module tb_mdio_apb_master;

  logic clk = 1'b0;
  logic PRESET = 1'b1;
  logic IRQ, MDC, MDIO_O, MDIO_T;
  logic MDIO_I = 1'b1;

  mdio_apb_master_if apb_bus ();

  mdio_apb_master dut (
    .PCLK   (clk),
    .PRESET (PRESET),
    .apb    (apb_bus),
    .IRQ    (IRQ),
    .MDC    (MDC),
    .MDIO_I (MDIO_I),
    .MDIO_O (MDIO_O),
    .MDIO_T (MDIO_T)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- PHY model and MDC monitor ----------------
  localparam logic [4:0] MODEL_PHY = 5'd1;
  logic [15:0] phy_regs [32];
  logic [63:0] cap;
  int          nb = 0;
  logic        rd_hit = 1'b0;
  logic        frame_rd = 1'b0;
  logic [15:0] rd_word = '0;
  int          t_err = 0;
  int          rise_total = 0;
  time         last_rise = 0, prev_rise = 0;

  initial for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0;

  always @(posedge MDC) begin
    rise_total = rise_total + 1;
    prev_rise  = last_rise;
    last_rise  = $time;
  end

  always @(posedge MDC or posedge PRESET) begin
    if (PRESET) begin
      nb = 0;
      rd_hit = 1'b0;
      frame_rd = 1'b0;
    end else begin
      cap = {cap[62:0], MDIO_O};
      if (nb < 46) begin
        if (MDIO_T !== 1'b0) t_err++;
      end else if (MDIO_T !== frame_rd) t_err++;
      nb++;
      if (nb == 46) begin
        frame_rd = (cap[11:10] == 2'b10);
        rd_hit   = frame_rd && (cap[13:12] == 2'b01) && (cap[9:5] == MODEL_PHY);
        rd_word  = phy_regs[cap[4:0]];
      end
      if (nb == 64) begin
        if (cap[63:32] == 32'hFFFF_FFFF && cap[31:30] == 2'b01 && cap[29:28] == 2'b01 &&
            cap[27:23] == MODEL_PHY && cap[17:16] == 2'b10)
          phy_regs[cap[22:18]] = cap[15:0];
        nb = 0;
        rd_hit = 1'b0;
        frame_rd = 1'b0;
      end
    end
  end

  // PHY presents each read data bit after the falling edge that precedes its rising edge
  always @(negedge MDC or posedge PRESET) begin
    if (PRESET) MDIO_I = 1'b1;
    else if (rd_hit && nb >= 48 && nb <= 63) MDIO_I = rd_word[4'(63 - nb)];
    else MDIO_I = 1'b1;
  end

  // ---------------- APB driver ----------------
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b1;
    apb_bus.PADDR = {24'd0, a}; apb_bus.PWDATA = d;
    @(negedge clk);
    apb_bus.PENABLE = 1'b1;
    @(negedge clk);
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = {24'd0, a};
    @(negedge clk);
    apb_bus.PENABLE = 1'b1;
    d = apb_bus.PRDATA;
    @(negedge clk);
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0;
  endtask

  // Polls STATUS until DONE or the budget runs out; caller checks the result
  task automatic wait_done(output logic [31:0] st);
    st = 32'hDEAD_BEEF;
    for (int i = 0; i < 3000; i++) begin
      apb_read(8'h34, st);
      if (st[1]) break;
    end
  endtask

  logic [15:0] exp_regs [32];

  task automatic do_write(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
    logic [31:0] st;
    apb_write(8'h38, {6'd0, phy, rg, d});
    if (phy == MODEL_PHY) exp_regs[rg] = d;
    wait_done(st);
    check_val($sformatf("wr_done r%0d", rg), st, 32'h2);
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] rg, output logic [31:0] v);
    logic [31:0] st;
    apb_write(8'h3C, {6'd0, phy, rg, 16'h0});
    wait_done(st);
    check_val($sformatf("rd_done r%0d", rg), st, 32'h2);
    apb_read(8'h3C, v);
  endtask

  logic [7:0]  rst_addr [16];
  logic [31:0] rst_exp  [16];

  initial begin
    logic [31:0] v, st;
    logic [15:0] d, d2;
    int r0;

    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = '0; apb_bus.PWDATA = '0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 16'h0;

    rst_addr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                 8'h20, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h24, 8'h2C, 8'h40};
    rst_exp  = '{32'h4D44494F, 32'h414D4241, 32'h20202020, 32'h20202020,
                 32'h46555455, 32'h52452044, 32'h45534947, 32'h4E202020,
                 32'h20181011, 32'h00000009, 32'h00000000, 32'hD4000000,
                 32'hD8000000, 32'h0, 32'h0, 32'h0};

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_mdc", {31'd0, MDC}, 32'd0);
    check_val("rst_mdio_t", {31'd0, MDIO_T}, 32'd1);
    check_val("rst_mdio_o", {31'd0, MDIO_O}, 32'd1);
    check_val("rst_irq", {31'd0, IRQ}, 32'd0);
    check_val("rst_prdata", apb_bus.PRDATA, 32'd0);
    PRESET = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apb_read(rst_addr[i], v);
      check_val($sformatf("csr_%02h", rst_addr[i]), v, rst_exp[i]);
    end

    // Write loopback at DIV=0
    apb_write(8'h30, 32'h8000_0000);
    r0 = rise_total;
    apb_write(8'h38, {6'd0, 5'd1, 5'd0, 16'h3524});
    exp_regs[0] = 16'h3524;
    apb_read(8'h34, st);
    check_val("busy", st, 32'h1);
    wait_done(st);
    check_val("wr_done", st, 32'h2);
    check_val("mdc_rises", rise_total - r0, 64);
    check_val("mdc_period_div0", 32'((last_rise - prev_rise) / 10), 32'd2);
    check_val("phy_reg0", {16'd0, phy_regs[0]}, 32'h3524);
    check_val("mdc_idle", {31'd0, MDC}, 32'd0);
    check_val("mdio_t_idle", {31'd0, MDIO_T}, 32'd1);
    do_read(5'd1, 5'd0, v);
    check_val("rdcmd_r0", v, {6'b110110, 5'd1, 5'd0, 16'h3524});

    // Random write-then-read loopback on registers 0..4
    for (int r = 0; r < 5; r++) begin
      d = 16'($urandom);
      do_write(5'd1, 5'(r), d);
      do_read(5'd1, 5'(r), v);
      check_val($sformatf("loop_r%0d", r), v, {6'b110110, 5'd1, 5'(r), exp_regs[r]});
    end
    // Absent PHY: pulled-up pad reads all ones
    do_read(5'd2, 5'd3, v);
    check_val("absent_phy", v, {6'b110110, 5'd2, 5'd3, 16'hFFFF});

    // IE=1, DIV=4: MDC period 10 PCLK, IRQ follows DONE
    apb_write(8'h30, 32'hC000_0004);
    check_val("irq_on_done", {31'd0, IRQ}, 32'd1);
    d = 16'($urandom);
    apb_write(8'h38, {6'd0, 5'd1, 5'd2, d});
    exp_regs[2] = d;
    check_val("irq_busy", {31'd0, IRQ}, 32'd0);
    wait_done(st);
    check_val("wr_done_div4", st, 32'h2);
    check_val("mdc_period_div4", 32'((last_rise - prev_rise) / 10), 32'd10);
    check_val("irq_set", {31'd0, IRQ}, 32'd1);
    apb_write(8'h34, 32'h2);
    apb_read(8'h34, st);
    check_val("done_clr", st, 32'h0);
    check_val("irq_clr", {31'd0, IRQ}, 32'd0);
    check_val("phy_reg2", {16'd0, phy_regs[2]}, {16'd0, exp_regs[2]});

    // Second command while busy is ignored
    d  = 16'($urandom);
    d2 = ~d;
    apb_write(8'h38, {6'd0, 5'd1, 5'd3, d});
    exp_regs[3] = d;
    apb_write(8'h38, {6'd0, 5'd1, 5'd5, d2});
    wait_done(st);
    check_val("busy_ign_done", st, 32'h2);
    check_val("busy_ign_r3", {16'd0, phy_regs[3]}, {16'd0, d});
    check_val("busy_ign_r5", {16'd0, phy_regs[5]}, {16'd0, exp_regs[5]});
    apb_read(8'h38, v);
    check_val("busy_ign_wrcmd", v, {6'b110101, 5'd1, 5'd3, d});

    // EN=0: command ignored, DONE kept
    apb_write(8'h30, 32'h0000_0004);
    r0 = rise_total;
    apb_write(8'h38, {6'd0, 5'd1, 5'd6, 16'hBEEF});
    apb_read(8'h34, st);
    check_val("en0_status", st, 32'h2);
    repeat (100) @(negedge clk);
    check_val("en0_no_mdc", rise_total - r0, 0);
    apb_read(8'h38, v);
    check_val("en0_wrcmd", v, {6'b110101, 5'd1, 5'd3, d});

    // Reset mid-frame
    apb_write(8'h30, 32'hC000_0001);
    apb_write(8'h38, {6'd0, 5'd1, 5'd4, 16'h1234});
    repeat (100) @(negedge clk);
    PRESET = 1'b1;
    #1;
    check_val("midrst_mdc", {31'd0, MDC}, 32'd0);
    check_val("midrst_mdio_t", {31'd0, MDIO_T}, 32'd1);
    check_val("midrst_mdio_o", {31'd0, MDIO_O}, 32'd1);
    check_val("midrst_prdata", apb_bus.PRDATA, 32'd0);
    repeat (2) @(negedge clk);
    PRESET = 1'b0;
    apb_read(8'h34, st);
    check_val("midrst_status", st, 32'h0);
    apb_read(8'h30, v);
    check_val("midrst_ctrl", v, 32'h9);
    check_val("midrst_r4_kept", {16'd0, phy_regs[4]}, {16'd0, exp_regs[4]});
    apb_write(8'h30, 32'h8000_0000);
    d = 16'($urandom);
    do_write(5'd1, 5'd7, d);
    do_read(5'd1, 5'd7, v);
    check_val("post_rst_loop", v, {6'b110110, 5'd1, 5'd7, d});
    check_val("mdio_t_frames", t_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
